// File: rtl/uart_bus_pkg.sv
// Shared types and byte constants for the UART-driven bus initiator.
package uart_bus_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  typedef enum logic [1:0] {SEND, WAIT_LO, WAIT_HI} phase_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/uart_bus_master_if.sv
// UART byte stream, sender handshake, peripheral bus and status signals of uart_bus_master.
interface uart_bus_master_if;

  logic        rx_status;
  logic [7:0]  rx_data;
  logic        tx_status;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        err_timeout;
  logic        overrun;

  modport master (
    input  rx_status, rx_data, tx_status, rdata,
    output tx_en, tx_data, rd, wr, addr, wdata, busy, err_timeout, overrun
  );

  modport slave (
    output rx_status, rx_data, tx_status, rdata,
    input  tx_en, tx_data, rd, wr, addr, wdata, busy, err_timeout, overrun
  );

endinterface

// File: rtl/uart_resp_tx.sv
// Sends 1-4 bytes of a response word MSB first; tx_en follows an idle sender by one cycle.
// Each byte waits for the sender to fall busy and return idle before the next is issued.
module uart_resp_tx
  import uart_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_word,
  input  logic [2:0]  i_count,
  input  logic        i_tx_status,
  output logic        o_tx_en,
  output logic [7:0]  o_tx_data,
  output logic        o_done
);

  phase_t      r_phase;
  logic        r_active;
  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_tx_en;
  logic [7:0]  r_tx_data;
  logic        r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase   <= SEND;
      r_active  <= 1'b0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      r_done  <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_phase  <= SEND;
        r_word   <= i_word;
        r_cnt    <= 2'(i_count - 3'd1);
      end else if (r_active) begin
        case (r_phase)
          SEND: if (i_tx_status) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= r_word[31:24];
            r_word    <= {r_word[23:0], 8'h00};
            r_phase   <= WAIT_LO;
          end
          WAIT_LO: if (!i_tx_status) r_phase <= WAIT_HI;
          WAIT_HI: if (i_tx_status) begin
            // r_cnt holds bytes remaining after this one; zero means the response is complete
            if (r_cnt == 2'd0) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end
            r_cnt   <= r_cnt - 2'd1;
            r_phase <= SEND;
          end
          default: r_phase <= SEND;
        endcase
      end
    end
  end

  assign o_tx_en   = r_tx_en;
  assign o_tx_data = r_tx_data;
  assign o_done    = r_done;

endmodule

// File: rtl/uart_bus_master.sv
// Turns UART command frames into single bus reads/writes; strobe one cycle after the last byte.
// Bytes arriving while the bus cycle or response is in progress are dropped and flagged in overrun.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  CMD_WR  = uart_bus_pkg::CMD_WR,
  parameter logic [7:0]  CMD_RD  = uart_bus_pkg::CMD_RD
) (
  input  logic              clk,
  input  logic              reset,
  uart_bus_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_is_rd;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_rd;
  logic          r_wr;
  logic          r_err_timeout;
  logic          r_overrun;

  logic          w_start;
  logic [31:0]   w_resp_word;
  logic [2:0]    w_resp_cnt;
  logic          w_done;
  logic          w_cmd_ok;

  assign w_cmd_ok = (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);

  // Response launches straight from BUS so rdata is captured in the strobe cycle
  always_comb begin
    w_start     = 1'b0;
    w_resp_word = {RSP_ERR, 24'h0};
    w_resp_cnt  = 3'd1;
    if (r_state == BUS) begin
      w_start = 1'b1;
      if (r_is_rd) begin
        w_resp_word = bus.rdata;
        w_resp_cnt  = 3'd4;
      end else begin
        w_resp_word = {RSP_ACK, 24'h0};
      end
    end else if (r_state == IDLE && bus.rx_status && !w_cmd_ok) begin
      w_start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_is_rd       <= 1'b0;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmo <= '0;
          r_cnt <= '0;
          if (bus.rx_status) begin
            if (w_cmd_ok) begin
              r_is_rd <= (bus.rx_data == CMD_RD);
              r_state <= ADDR;
            end else begin
              r_state <= RESP;
            end
          end
        end
        ADDR, DATA: begin
          // Timeout outranks a byte landing in the same cycle
          if (r_tmo == TMO_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tmo         <= '0;
          end else if (bus.rx_status) begin
            r_tmo <= '0;
            r_cnt <= r_cnt + 2'd1;
            if (r_state == ADDR) r_addr  <= {r_addr[23:0], bus.rx_data};
            else                 r_wdata <= {r_wdata[23:0], bus.rx_data};
            if (r_cnt == 2'd3) begin
              if (r_state == ADDR && !r_is_rd) begin
                r_state <= DATA;
              end else begin
                r_state <= BUS;
                r_rd    <= r_is_rd;
                r_wr    <= !r_is_rd;
              end
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        BUS: begin
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_state <= RESP;
          if (bus.rx_status) r_overrun <= 1'b1;
        end
        RESP: begin
          if (bus.rx_status) r_overrun <= 1'b1;
          if (w_done)        r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_resp_tx u_resp_tx (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_word      (w_resp_word),
    .i_count     (w_resp_cnt),
    .i_tx_status (bus.tx_status),
    .o_tx_en     (bus.tx_en),
    .o_tx_data   (bus.tx_data),
    .o_done      (w_done)
  );

  assign bus.rd          = r_rd;
  assign bus.wr          = r_wr;
  assign bus.addr        = r_addr;
  assign bus.wdata       = r_wdata;
  assign bus.busy        = (r_state != IDLE);
  assign bus.err_timeout = r_err_timeout;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed frames against a frame-level model; a per-cycle compare process checks bus strobes, tx bytes and flags.
module tb_uart_bus_master;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;

  uart_bus_master_if u_if ();

  uart_bus_master #(.TIMEOUT(TMO), .CMD_WR(8'h57), .CMD_RD(8'h52)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  int          checks = 0;
  int          errors = 0;
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  seen_tx[$];
  logic        exp_overrun = 1'b0;
  logic        tmo_window  = 1'b0;
  int          tmo_pulses  = 0;
  logic [31:0] rdata_val   = '0;
  bus_t        chk_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Frame-level model: what a complete frame must produce on the bus and the sender
  task automatic model_frame(input logic [7:0] f [0:8], input int n);
    bus_t t;
    if (n == 9 && f[0] == 8'h57) begin
      t.is_rd = 1'b0;
      t.addr  = {f[1], f[2], f[3], f[4]};
      t.wdata = {f[5], f[6], f[7], f[8]};
      exp_bus.push_back(t);
      exp_tx.push_back(8'h4B);
    end else if (n == 5 && f[0] == 8'h52) begin
      t.is_rd = 1'b1;
      t.addr  = {f[1], f[2], f[3], f[4]};
      t.wdata = '0;
      exp_bus.push_back(t);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata_val[8*i +: 8]);
    end else if (n == 1 && f[0] != 8'h57 && f[0] != 8'h52) begin
      exp_tx.push_back(8'h45);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ovr);
    @(negedge clk);
    u_if.rx_status = 1'b1;
    u_if.rx_data   = b;
    if (ovr) exp_overrun = 1'b1;
    @(negedge clk);
    u_if.rx_status = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] f [0:8], input int n);
    model_frame(f, n);
    for (int i = 0; i < n; i++) send_byte(f[i], 1'b0);
  endtask

  task automatic wait_tx_en(input string name);
    int n = 0;
    while (u_if.tx_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, u_if.tx_en, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((u_if.busy !== 1'b0 || exp_tx.size() != 0) && n < 500);
    check({name, "_busy"}, u_if.busy, 1'b0);
    check({name, "_tx_left"}, exp_tx.size(), 0);
    check({name, "_bus_left"}, exp_bus.size(), 0);
  endtask

  // Sender model: falls busy the cycle after tx_en, idle again four cycles later
  initial begin
    u_if.tx_status = 1'b1;
    forever begin
      @(negedge clk);
      if (u_if.tx_en === 1'b1) begin
        @(negedge clk);
        check("tx_en_width", u_if.tx_en, 1'b0);
        u_if.tx_status = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("tx_en_while_sending", u_if.tx_en, 1'b0);
        end
        u_if.tx_status = 1'b1;
      end
    end
  end

  // Compare process, sampling mid-cycle away from both clock edges
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (reset === 1'b1) begin
        if (u_if.rd === 1'b1 || u_if.wr === 1'b1) begin
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: rd=%0b wr=%0b addr=%h, required no strobe",
                     u_if.rd, u_if.wr, u_if.addr);
          end else begin
            chk_t = exp_bus.pop_front();
            check("bus_rd", u_if.rd, chk_t.is_rd);
            check("bus_wr", u_if.wr, !chk_t.is_rd);
            check("bus_addr", u_if.addr, chk_t.addr);
            if (!chk_t.is_rd) check("bus_wdata", u_if.wdata, chk_t.wdata);
          end
        end
        if (u_if.tx_en === 1'b1) begin
          seen_tx.push_back(u_if.tx_data);
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: tx_data=%h, required no byte", u_if.tx_data);
          end else begin
            check("tx_data", u_if.tx_data, exp_tx.pop_front());
          end
        end
        if (u_if.err_timeout === 1'b1) begin
          tmo_pulses++;
          check("err_timeout_allowed", u_if.err_timeout, tmo_window);
        end
        check("overrun", u_if.overrun, exp_overrun);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f [0:8];
    int lat;

    reset          = 1'b0;
    u_if.rx_status = 1'b0;
    u_if.rx_data   = '0;
    u_if.rdata     = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", u_if.tx_en, 1'b0);
    check("rst_tx_data", u_if.tx_data, 8'h00);
    check("rst_rd", u_if.rd, 1'b0);
    check("rst_wr", u_if.wr, 1'b0);
    check("rst_addr", u_if.addr, 32'h0);
    check("rst_wdata", u_if.wdata, 32'h0);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_err_timeout", u_if.err_timeout, 1'b0);
    check("rst_overrun", u_if.overrun, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write frame, then latency from the last byte to the first tx_en
    f = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hA5};
    seen_tx.delete();
    run_frame(f, 9);
    check("wr_strobe", u_if.wr, 1'b1);
    check("wr_addr_lit", u_if.addr, 32'h4000000C);
    check("wr_wdata_lit", u_if.wdata, 32'h000000A5);
    check("wr_busy", u_if.busy, 1'b1);
    lat = 1;
    while (u_if.tx_en !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("wr_latency", lat, 3);
    check("wr_ack_lit", u_if.tx_data, 8'h4B);
    wait_idle("wr");
    check("wr_seen_count", seen_tx.size(), 1);

    // Read frame; rdata changes after the strobe cycle to prove it was captured
    rdata_val  = 32'h12345678;
    u_if.rdata = rdata_val;
    f = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    seen_tx.delete();
    run_frame(f, 5);
    check("rd_strobe", u_if.rd, 1'b1);
    check("rd_addr_lit", u_if.addr, 32'h40000010);
    check("rd_wdata_hold", u_if.wdata, 32'h000000A5);
    @(negedge clk);
    u_if.rdata = 32'hDEADBEEF;
    check("rd_addr_hold", u_if.addr, 32'h40000010);
    wait_idle("rd");
    check("rd_seen_count", seen_tx.size(), 4);
    if (seen_tx.size() == 4) begin
      check("rd_byte0_lit", seen_tx[0], 8'h12);
      check("rd_byte1_lit", seen_tx[1], 8'h34);
      check("rd_byte2_lit", seen_tx[2], 8'h56);
      check("rd_byte3_lit", seen_tx[3], 8'h78);
    end

    // Unknown command byte
    f = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    seen_tx.delete();
    run_frame(f, 1);
    wait_idle("bad");
    check("bad_seen_count", seen_tx.size(), 1);
    if (seen_tx.size() == 1) check("bad_byte_lit", seen_tx[0], 8'h45);

    // Truncated write frame abandoned by the inter-byte timeout
    tmo_window = 1'b1;
    tmo_pulses = 0;
    seen_tx.delete();
    send_byte(8'h57, 1'b0);
    send_byte(8'h40, 1'b0);
    lat = 0;
    while (u_if.err_timeout !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("tmo_cycles", lat, 16);
    check("tmo_busy", u_if.busy, 1'b0);
    @(negedge clk);
    check("tmo_pulse_width", u_if.err_timeout, 1'b0);
    repeat (20) @(negedge clk);
    tmo_window = 1'b0;
    check("tmo_pulse_count", tmo_pulses, 1);
    check("tmo_no_response", seen_tx.size(), 0);
    rdata_val  = 32'hCAFEF00D;
    u_if.rdata = rdata_val;
    f = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(f, 5);
    wait_idle("post_tmo");

    // Byte injected during a read response
    rdata_val  = 32'hA1B2C3D4;
    u_if.rdata = rdata_val;
    f = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    seen_tx.delete();
    run_frame(f, 5);
    wait_tx_en("ovr_first_tx");
    send_byte(8'h99, 1'b1);
    wait_idle("ovr");
    check("ovr_flag_lit", u_if.overrun, 1'b1);
    check("ovr_seen_count", seen_tx.size(), 4);
    if (seen_tx.size() == 4) check("ovr_byte1_lit", seen_tx[1], 8'hB2);

    // Reset while the second response byte is being issued
    rdata_val  = 32'h0BADF00D;
    u_if.rdata = rdata_val;
    f = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(f, 5);
    wait_tx_en("rst_first_tx");
    @(negedge clk);
    wait_tx_en("rst_second_tx");
    reset = 1'b0;
    exp_tx.delete();
    exp_bus.delete();
    exp_overrun = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_en", u_if.tx_en, 1'b0);
    check("rst_mid_overrun", u_if.overrun, 1'b0);
    check("rst_mid_busy", u_if.busy, 1'b0);
    check("rst_mid_addr", u_if.addr, 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    f = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(f, 9);
    check("recov_wdata_lit", u_if.wdata, 32'hDEADBEEF);
    wait_idle("recov");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
